// File: rtl/mul_pkg.sv
// Shared types and default sizes for the shift-add multiplier blocks.
package mul_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } mul_state_t;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = 6;
endpackage

// File: rtl/mul_iter_counter.sv
// Iteration counter for the multiplier sequencer: clear, enable, saturate at WIDTH.
module mul_iter_counter
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] MAX  = CNT_W'(WIDTH);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)                    count <= '0;
    else if (clr)                 count <= '0;
    else if (en && count < MAX)   count <= count + CNT_W'(1);
  end

  assign tc = (count == LAST);
endmodule

// File: rtl/multiplier_control.sv
// Sequencer for the shift-add multiplier: LOAD strobe, WIDTH shift/add cycles, then Ready.
// Outputs are registered from the next state so nothing depends combinationally on Run/Ack.
module multiplier_control
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             Ack,
  output logic             W_ctrl,
  output logic             SRL_ctrl,
  output logic             ALU_en,
  output logic             Ready,
  output logic             Busy,
  output logic [CNT_W-1:0] Iter
);
  mul_state_t state, nxt;
  logic       tc, over, cnt_clr, cnt_en;

  // A count past WIDTH can only come from corruption; treat it like a bad state.
  assign over = (Iter > CNT_W'(WIDTH));

  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = Run ? LOAD : IDLE;
      LOAD:    nxt = CALC;
      CALC:    nxt = tc ? DONE : CALC;
      DONE:    nxt = Run ? LOAD : (Ack ? IDLE : DONE);
      default: nxt = IDLE;
    endcase
    if (over) nxt = IDLE;
  end

  assign cnt_clr = (nxt == IDLE) || (nxt == LOAD);
  assign cnt_en  = (state == CALC);

  mul_iter_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .Reset (Reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (Iter),
    .tc    (tc)
  );

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      W_ctrl   <= 1'b0;
      SRL_ctrl <= 1'b0;
      ALU_en   <= 1'b0;
      Ready    <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      state    <= nxt;
      W_ctrl   <= (nxt == LOAD);
      SRL_ctrl <= (nxt == CALC);
      ALU_en   <= (nxt == CALC);
      Ready    <= (nxt == DONE);
      Busy     <= (nxt == LOAD) || (nxt == CALC);
    end
  end
endmodule

// File: tb/tb_multiplier_control.sv
// Bench for multiplier_control: phase-count reference model plus a falling-edge shift-add datapath.
module tb_multiplier_control;
  localparam int W  = 32;
  localparam int CW = 6;

  logic          clk, Reset, Run, Ack;
  logic          W_ctrl, SRL_ctrl, ALU_en, Ready, Busy;
  logic [CW-1:0] Iter;

  multiplier_control #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .Reset(Reset), .Run(Run), .Ack(Ack),
    .W_ctrl(W_ctrl), .SRL_ctrl(SRL_ctrl), .ALU_en(ALU_en),
    .Ready(Ready), .Busy(Busy), .Iter(Iter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath driven by the DUT strobes, sampled on the falling edge.
  logic [31:0] mcand, mplier, ma;
  logic [63:0] prod, exp_p;
  int          nsrl;
  always @(negedge clk) begin
    if (W_ctrl) begin
      prod  <= {32'd0, mplier};
      ma    <= mcand;
      exp_p <= 64'(mcand) * 64'(mplier);
      nsrl  <= 0;
    end else if (SRL_ctrl) begin
      prod  <= {({1'b0, prod[63:32]} + (prod[0] ? {1'b0, ma} : 33'd0)), prod[31:1]};
      nsrl  <= nsrl + 1;
    end
  end

  // Model: ph=-1 idle, 0 load, 1..W shift cycle number, W+1 done.
  int ph, prev_ph;
  int cmp, mis;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    chk("W_ctrl",   64'(W_ctrl),   64'(ph == 0));
    chk("SRL_ctrl", 64'(SRL_ctrl), 64'(ph >= 1 && ph <= W));
    chk("ALU_en",   64'(ALU_en),   64'(ph >= 1 && ph <= W));
    chk("Ready",    64'(Ready),    64'(ph == W + 1));
    chk("Busy",     64'(Busy),     64'(ph >= 0 && ph <= W));
    chk("Iter",     64'(Iter),     64'((ph <= 0) ? 0 : (ph <= W) ? ph - 1 : W));
    if (ph == W + 1 && prev_ph == W) begin
      chk("srl_cnt", 64'(nsrl), 64'(W));
      chk("product", prod, exp_p);
    end
  endtask

  task automatic tick(input logic r, input logic a);
    Run = r; Ack = a;
    @(posedge clk);
    prev_ph = ph;
    if (Reset)          ph = -1;
    else if (ph < 0)    ph = r ? 0 : -1;
    else if (ph <= W)   ph = ph + 1;
    else if (r)         ph = 0;
    else if (a)         ph = -1;
    #1 check_outs();
  endtask

  initial begin
    cmp = 0; mis = 0; ph = -1; prev_ph = -1;
    Reset = 1'b1; Run = 1'b0; Ack = 1'b0;
    mcand = 32'd0; mplier = 32'd0;
    #1 check_outs();

    // Reset then idle
    tick(0, 0); tick(0, 0);
    Reset = 1'b0;
    repeat (10) tick(0, 0);

    // 7 x 9
    mcand = 32'd7; mplier = 32'd9;
    tick(1, 0);
    repeat (W + 3) tick(0, 0);
    chk("prod_7x9", prod, 64'h0000_0000_0000_003F);
    tick(0, 1);
    repeat (3) tick(0, 0);

    // all-ones squared
    mcand = 32'hFFFF_FFFF; mplier = 32'hFFFF_FFFF;
    tick(1, 0);
    repeat (W + 2) tick(0, 0);
    chk("prod_ff", prod, 64'hFFFF_FFFE_0000_0001);
    tick(0, 1);
    tick(0, 0);

    // Asynchronous reset with Iter at 17
    mcand = $urandom; mplier = $urandom;
    tick(1, 0);
    begin
      int n;
      n = 0;
      while (ph != 18 && n < 40) begin tick(0, 0); n++; end
      chk("reach_iter17", 64'(n < 40), 64'd1);
    end
    #2 Reset = 1'b1;
    #1 begin ph = -1; prev_ph = -1; check_outs(); end
    tick(0, 0);
    Reset = 1'b0;
    mcand = $urandom; mplier = $urandom;
    tick(1, 0);
    repeat (W + 2) tick(0, 0);
    tick(0, 1);

    // Run/Ack noise during the shift phase
    mcand = $urandom; mplier = $urandom;
    tick(1, 0);
    while (ph >= 0 && ph <= W) tick(1'($urandom), 1'($urandom));
    tick(0, 1);

    // Back-to-back with Run held high, then Run+Ack together in DONE
    mcand = $urandom; mplier = $urandom;
    repeat (3 * (W + 2)) tick(1, 0);
    while (ph != W + 1) tick(0, 0);
    tick(1, 1);
    chk("runack_load", 64'(W_ctrl), 64'd1);
    repeat (W + 1) tick(0, 0);
    tick(0, 1);

    // Random traffic
    repeat (400) begin
      mcand = $urandom; mplier = $urandom;
      tick(1'($urandom_range(0, 7) == 0), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
